// File: rtl/pipe_pkg.sv
// Shared constants for the EX stage: ALU opcodes, muldiv opcodes, forward selects
// and the muldiv FSM state type.
package pipe_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_W  = 5;
    localparam int DEF_MD_CYC = 32;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_NOR  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_SLTU = 4'b1011;
    localparam logic [3:0] ALU_LUI  = 4'b1100;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIVU  = 3'd2;
    localparam logic [2:0] MD_MFHI  = 3'd3;
    localparam logic [2:0] MD_MFLO  = 3'd4;

    localparam logic [1:0] FWD_RD = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;

    // Codes 5..7 are treated exactly like NONE.
    function automatic logic md_is_valid(input logic [2:0] op);
        return (op >= MD_MULTU) && (op <= MD_MFLO);
    endfunction

    function automatic logic md_is_start(input logic [2:0] op);
        return (op == MD_MULTU) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply / restoring divide, one bit per cycle, with HI/LO.
// The accumulator holds {upper, lower} and both ops start from {0, a}.
module muldiv_unit
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int MD_CYC = DEF_MD_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [2:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_busy,
    output logic [DATA_W-1:0] o_hi,
    output logic [DATA_W-1:0] o_lo
);

    localparam int CNT_W = $clog2(MD_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_CYC - 1);

    md_state_e             r_state;
    md_state_e             w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_div;
    logic [DATA_W-1:0]     r_b;
    logic [2*DATA_W-1:0]   r_acc;
    logic [DATA_W-1:0]     r_hi;
    logic [DATA_W-1:0]     r_lo;

    logic [DATA_W:0]       w_mul_sum;
    logic [DATA_W:0]       w_div_shift;
    logic                  w_div_ge;
    logic [DATA_W-1:0]     w_div_diff;
    logic [2*DATA_W-1:0]   w_acc_nxt;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MD_IDLE: if (i_start) w_state_nxt = MD_BUSY;
            MD_BUSY: if (r_cnt == CNT_LAST) w_state_nxt = MD_IDLE;
            default: w_state_nxt = MD_IDLE;
        endcase
    end

    // Divide by zero needs no special case: every trial subtract succeeds,
    // giving an all-ones quotient and the dividend shifted into the remainder.
    always_comb begin
        w_mul_sum   = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + (r_acc[0] ? {1'b0, r_b} : '0);
        w_div_shift = r_acc[2*DATA_W-1:DATA_W-1];
        w_div_ge    = (w_div_shift >= {1'b0, r_b});
        w_div_diff  = w_div_shift[DATA_W-1:0] - r_b;
        if (r_div) begin
            if (w_div_ge) w_acc_nxt = {w_div_diff, r_acc[DATA_W-2:0], 1'b1};
            else          w_acc_nxt = {w_div_shift[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b0};
        end else begin
            w_acc_nxt = {w_mul_sum, r_acc[DATA_W-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
            r_div   <= 1'b0;
            r_b     <= '0;
            r_acc   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                MD_IDLE: begin
                    if (i_start) begin
                        r_acc <= {{DATA_W{1'b0}}, i_a};
                        r_b   <= i_b;
                        r_div <= (i_op == MD_DIVU);
                        r_cnt <= '0;
                    end
                end
                MD_BUSY: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_hi <= w_acc_nxt[2*DATA_W-1:DATA_W];
                        r_lo <= w_acc_nxt[DATA_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy = (r_state == MD_BUSY);
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: operand forwarding, ALU, RegDst mux, muldiv unit and the
// EX/MEM pipeline latch.
module ex_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_W  = DEF_REG_W,
    parameter int MD_CYC = DEF_MD_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RegWriteE,
    input  logic              MemtoRegE,
    input  logic              MemWriteE,
    input  logic              ALUSrcE,
    input  logic              RegDstE,
    input  logic [3:0]        ALUControlE,
    input  logic [2:0]        MdOpE,
    input  logic [DATA_W-1:0] RD1E,
    input  logic [DATA_W-1:0] RD2E,
    input  logic [DATA_W-1:0] SignImmE,
    input  logic [REG_W-1:0]  RtE,
    input  logic [REG_W-1:0]  RdE,
    input  logic [1:0]        ForwardAE,
    input  logic [1:0]        ForwardBE,
    input  logic [DATA_W-1:0] ResultW,
    output logic              StallMD,
    output logic              RegWriteM,
    output logic              MemtoRegM,
    output logic              MemWriteM,
    output logic [DATA_W-1:0] ALUOutM,
    output logic [DATA_W-1:0] WriteDataM,
    output logic [REG_W-1:0]  WriteRegM
);

    logic [DATA_W-1:0] w_src_a;
    logic [DATA_W-1:0] w_fwd_b;
    logic [DATA_W-1:0] w_src_b;
    logic [4:0]        w_shamt;
    logic [DATA_W-1:0] w_alu;
    logic [DATA_W-1:0] w_result;
    logic [REG_W-1:0]  w_write_reg;
    logic              w_busy;
    logic              w_bubble;
    logic [DATA_W-1:0] w_hi;
    logic [DATA_W-1:0] w_lo;

    always_comb begin
        case (ForwardAE)
            FWD_W:   w_src_a = ResultW;
            FWD_M:   w_src_a = ALUOutM;
            default: w_src_a = RD1E;
        endcase
        case (ForwardBE)
            FWD_W:   w_fwd_b = ResultW;
            FWD_M:   w_fwd_b = ALUOutM;
            default: w_fwd_b = RD2E;
        endcase
    end

    assign w_src_b     = ALUSrcE ? SignImmE : w_fwd_b;
    assign w_shamt     = SignImmE[10:6];
    assign w_write_reg = RegDstE ? RdE : RtE;

    always_comb begin
        w_alu = '0;
        case (ALUControlE)
            ALU_AND:  w_alu = w_src_a & w_src_b;
            ALU_OR:   w_alu = w_src_a | w_src_b;
            ALU_ADD:  w_alu = w_src_a + w_src_b;
            ALU_XOR:  w_alu = w_src_a ^ w_src_b;
            ALU_NOR:  w_alu = ~(w_src_a | w_src_b);
            ALU_SUB:  w_alu = w_src_a - w_src_b;
            ALU_SLT:  w_alu = {{(DATA_W-1){1'b0}}, $signed(w_src_a) < $signed(w_src_b)};
            ALU_SLTU: w_alu = {{(DATA_W-1){1'b0}}, w_src_a < w_src_b};
            ALU_SLL:  w_alu = w_src_b << w_shamt;
            ALU_SRL:  w_alu = w_src_b >> w_shamt;
            ALU_SRA:  w_alu = $signed(w_src_b) >>> w_shamt;
            ALU_LUI:  w_alu = w_src_b << 16;
            default:  w_alu = '0;
        endcase
    end

    always_comb begin
        case (MdOpE)
            MD_MFHI: w_result = w_hi;
            MD_MFLO: w_result = w_lo;
            default: w_result = w_alu;
        endcase
    end

    muldiv_unit #(
        .DATA_W (DATA_W),
        .MD_CYC (MD_CYC)
    ) u_muldiv (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (md_is_start(MdOpE)),
        .i_op    (MdOpE),
        .i_a     (w_src_a),
        .i_b     (w_fwd_b),
        .o_busy  (w_busy),
        .o_hi    (w_hi),
        .o_lo    (w_lo)
    );

    // HI/LO are not bypassed, so any muldiv op in EX waits out a running operation.
    assign StallMD  = w_busy && md_is_valid(MdOpE);
    assign w_bubble = StallMD || md_is_start(MdOpE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWriteM  <= 1'b0;
            MemtoRegM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ALUOutM    <= '0;
            WriteDataM <= '0;
            WriteRegM  <= '0;
        end else if (w_bubble) begin
            RegWriteM  <= 1'b0;
            MemtoRegM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ALUOutM    <= '0;
            WriteDataM <= '0;
            WriteRegM  <= '0;
        end else begin
            RegWriteM  <= RegWriteE;
            MemtoRegM  <= MemtoRegE;
            MemWriteM  <= MemWriteE;
            ALUOutM    <= w_result;
            WriteDataM <= w_fwd_b;
            WriteRegM  <= w_write_reg;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: each issued instruction pushes its expected EX/MEM
// contents, which are popped and compared one cycle later.
module tb_ex_stage;
    import pipe_pkg::*;

    localparam logic [4:0] RT_IDX = 5'd5;
    localparam logic [4:0] RD_IDX = 5'd9;
    localparam logic [31:0] RES_W = 32'h0000_0010;
    // ctl = {RegDst, RegWrite, MemtoReg, MemWrite}
    localparam logic [3:0] C_RW = 4'b0100;
    localparam logic [3:0] C_RD = 4'b1100;
    localparam logic [3:0] C_LD = 4'b0110;
    localparam logic [3:0] C_ST = 4'b0001;

    logic clk = 1'b0;
    logic rst_n;
    logic RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE;
    logic [3:0] ALUControlE;
    logic [2:0] MdOpE;
    logic [31:0] RD1E, RD2E, SignImmE, ResultW;
    logic [4:0] RtE, RdE;
    logic [1:0] ForwardAE, ForwardBE;
    logic StallMD, RegWriteM, MemtoRegM, MemWriteM;
    logic [31:0] ALUOutM, WriteDataM;
    logic [4:0] WriteRegM;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  wr;
        logic        rw;
        logic        mtr;
        logic        mw;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    int    total = 0;
    int    bad = 0;

    ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
        .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .ALUControlE(ALUControlE), .MdOpE(MdOpE),
        .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE), .RtE(RtE), .RdE(RdE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
        .StallMD(StallMD), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
        .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin : sb_chk
        exp_t  e;
        exp_t  got;
        string t;
        #1;
        if (sb_q.size() != 0) begin
            e   = sb_q.pop_front();
            t   = tag_q.pop_front();
            got = {ALUOutM, WriteDataM, WriteRegM, RegWriteM, MemtoRegM, MemWriteM};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL %s: got alu=%h wd=%h wr=%0d ctl=%b%b%b, required alu=%h wd=%h wr=%0d ctl=%b%b%b",
                         t, got.alu, got.wd, got.wr, got.rw, got.mtr, got.mw,
                         e.alu, e.wd, e.wr, e.rw, e.mtr, e.mw);
            end
        end
    end

    task automatic op(input string tag, input logic [3:0] alu, input logic [2:0] md,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                      input logic src, input logic [1:0] fa, input logic [1:0] fb,
                      input logic [3:0] ctl, input logic bubble,
                      input logic [31:0] e_alu, input logic [31:0] e_wd);
        exp_t e;
        @(negedge clk);
        ALUControlE = alu; MdOpE = md; RD1E = a; RD2E = b; SignImmE = imm;
        ALUSrcE = src; ForwardAE = fa; ForwardBE = fb;
        RegDstE = ctl[3]; RegWriteE = ctl[2]; MemtoRegE = ctl[1]; MemWriteE = ctl[0];
        if (bubble) e = '0;
        else e = {e_alu, e_wd, (ctl[3] ? RD_IDX : RT_IDX), ctl[2], ctl[1], ctl[0]};
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        RtE = RT_IDX; RdE = RD_IDX; ResultW = RES_W;
        ALUControlE = ALU_ADD; MdOpE = MD_NONE; RD1E = 32'h11; RD2E = 32'h22; SignImmE = 32'h3;
        ALUSrcE = 1'b0; ForwardAE = 2'b00; ForwardBE = 2'b00;
        RegDstE = 1'b1; RegWriteE = 1'b1; MemtoRegE = 1'b1; MemWriteE = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({ALUOutM, WriteDataM, WriteRegM, RegWriteM, MemtoRegM, MemWriteM, StallMD} !== '0) begin
            bad++;
            $display("FAIL reset: alu=%h wd=%h wr=%0d ctl=%b%b%b stall=%b, required all 0",
                     ALUOutM, WriteDataM, WriteRegM, RegWriteM, MemtoRegM, MemWriteM, StallMD);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_alu();
        op("add_imm",  ALU_ADD,  MD_NONE, 32'd3, 32'd0, 32'd4, 1'b1, 2'b00, 2'b00, C_RW, 1'b0, 32'd7, 32'd0);
        op("fwd_m_a",  ALU_ADD,  MD_NONE, 32'd5, 32'h55, 32'd3, 1'b1, 2'b10, 2'b00, C_RW, 1'b0, 32'd10, 32'h55);
        op("fwd_w_b",  ALU_SUB,  MD_NONE, 32'h30, 32'h99, 32'd0, 1'b0, 2'b00, 2'b01, C_RD, 1'b0, 32'h20, RES_W);
        op("fwd_m_b",  ALU_OR,   MD_NONE, 32'd1, 32'd0, 32'd0, 1'b0, 2'b00, 2'b10, C_RD, 1'b0, 32'h21, 32'h20);
        op("fwd_11",   ALU_ADD,  MD_NONE, 32'd2, 32'd3, 32'd0, 1'b0, 2'b11, 2'b11, C_RW, 1'b0, 32'd5, 32'd3);
        op("slt",      ALU_SLT,  MD_NONE, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 2'b00, 2'b00, C_RW, 1'b0, 32'd1, 32'd1);
        op("sltu",     ALU_SLTU, MD_NONE, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 2'b00, 2'b00, C_RW, 1'b0, 32'd0, 32'd1);
        op("slt_pos",  ALU_SLT,  MD_NONE, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 2'b00, 2'b00, C_RW, 1'b0, 32'd0, 32'hFFFF_FFFF);
        op("sltu_pos", ALU_SLTU, MD_NONE, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 2'b00, 2'b00, C_RW, 1'b0, 32'd1, 32'hFFFF_FFFF);
        op("sra",      ALU_SRA,  MD_NONE, 32'd0, 32'h8000_0000, 32'h100, 1'b0, 2'b00, 2'b00, C_RW, 1'b0, 32'hF800_0000, 32'h8000_0000);
        op("srl",      ALU_SRL,  MD_NONE, 32'd0, 32'h8000_0000, 32'h100, 1'b0, 2'b00, 2'b00, C_RW, 1'b0, 32'h0800_0000, 32'h8000_0000);
        op("sll",      ALU_SLL,  MD_NONE, 32'd0, 32'd1, 32'h200, 1'b0, 2'b00, 2'b00, C_RD, 1'b0, 32'h100, 32'd1);
        op("lui",      ALU_LUI,  MD_NONE, 32'd0, 32'd7, 32'h1234, 1'b1, 2'b00, 2'b00, C_LD, 1'b0, 32'h1234_0000, 32'd7);
        op("and",      ALU_AND,  MD_NONE, 32'hF0F0, 32'hFF00, 32'd0, 1'b0, 2'b00, 2'b00, C_ST, 1'b0, 32'hF000, 32'hFF00);
        op("xor",      ALU_XOR,  MD_NONE, 32'hF0F0, 32'hFF00, 32'd0, 1'b0, 2'b00, 2'b00, C_RW, 1'b0, 32'h0FF0, 32'hFF00);
        op("nor",      ALU_NOR,  MD_NONE, 32'hF0F0, 32'hFF00, 32'd0, 1'b0, 2'b00, 2'b00, C_RW, 1'b0, 32'hFFFF_000F, 32'hFF00);
        op("add_wrap", ALU_ADD,  MD_NONE, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 2'b00, 2'b00, C_RW, 1'b0, 32'd1, 32'd2);
        op("sub_neg",  ALU_SUB,  MD_NONE, 32'd1, 32'd2, 32'd0, 1'b0, 2'b00, 2'b00, C_RW, 1'b0, 32'hFFFF_FFFF, 32'd2);
        op("undef",    4'b0101,  MD_NONE, 32'd5, 32'd6, 32'd0, 1'b0, 2'b00, 2'b00, C_RW, 1'b0, 32'd0, 32'd6);
        op("md5_none", ALU_ADD,  3'd5, 32'd1, 32'd1, 32'd0, 1'b0, 2'b00, 2'b00, C_RW, 1'b0, 32'd2, 32'd1);
    endtask

    task automatic test_multu_stall();
        op("multu", ALU_ADD, MD_MULTU, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 2'b00, 2'b00, C_RW, 1'b1, 32'd0, 32'd0);
        for (int i = 0; i < 32; i++) begin
            op($sformatf("mfhi_stall%0d", i), ALU_ADD, MD_MFHI, 32'd0, 32'h44, 32'd0, 1'b0, 2'b00, 2'b00, C_RD, 1'b1, 32'd0, 32'd0);
            #1;
            total++;
            if (StallMD !== 1'b1) begin
                bad++;
                $display("FAIL stall_busy%0d: StallMD=%b required 1", i, StallMD);
            end
        end
        op("mfhi", ALU_ADD, MD_MFHI, 32'd0, 32'h44, 32'd0, 1'b0, 2'b00, 2'b00, C_RD, 1'b0, 32'd1, 32'h44);
        #1;
        total++;
        if (StallMD !== 1'b0) begin
            bad++;
            $display("FAIL stall_release: StallMD=%b required 0", StallMD);
        end
        op("mflo", ALU_ADD, MD_MFLO, 32'd0, 32'h44, 32'd0, 1'b0, 2'b00, 2'b00, C_RD, 1'b0, 32'hFFFF_FFFE, 32'h44);
    endtask

    // Keeps the pipe busy with independent ADDs (one tagged MdOp 5) while muldiv runs.
    task automatic run_independent(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            op($sformatf("%s_add%0d", name, i), ALU_ADD, (i == 5) ? 3'd5 : MD_NONE,
               32'(i), 32'h77, 32'd100, 1'b1, 2'b00, 2'b00, C_RW, 1'b0, 32'(i + 100), 32'h77);
            #1;
            total++;
            if (StallMD !== 1'b0) begin
                bad++;
                $display("FAIL %s_nostall%0d: StallMD=%b required 0", name, i, StallMD);
            end
        end
    endtask

    task automatic test_back_to_back();
        op("multu2", ALU_ADD, MD_MULTU, 32'h0001_0001, 32'h0001_0001, 32'd0, 1'b0, 2'b00, 2'b00, C_RW, 1'b1, 32'd0, 32'd0);
        run_independent("mul2", 32);
        op("mfhi2", ALU_ADD, MD_MFHI, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 2'b00, C_RW, 1'b0, 32'd1, 32'd0);
        op("mflo2", ALU_ADD, MD_MFLO, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 2'b00, C_RW, 1'b0, 32'h0002_0001, 32'd0);
    endtask

    task automatic test_divu();
        op("divu", ALU_ADD, MD_DIVU, 32'd100, 32'd7, 32'd0, 1'b0, 2'b00, 2'b00, C_RW, 1'b1, 32'd0, 32'd0);
        run_independent("div", 32);
        op("div_lo", ALU_ADD, MD_MFLO, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 2'b00, C_RW, 1'b0, 32'd14, 32'd0);
        op("div_hi", ALU_ADD, MD_MFHI, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 2'b00, C_RW, 1'b0, 32'd2, 32'd0);
        op("divu0", ALU_ADD, MD_DIVU, 32'd100, 32'd0, 32'd0, 1'b0, 2'b00, 2'b00, C_RW, 1'b1, 32'd0, 32'd0);
        run_independent("div0", 32);
        op("div0_lo", ALU_ADD, MD_MFLO, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 2'b00, C_RW, 1'b0, 32'hFFFF_FFFF, 32'd0);
        op("div0_hi", ALU_ADD, MD_MFHI, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 2'b00, C_RW, 1'b0, 32'd100, 32'd0);
    endtask

    task automatic test_reset_busy();
        op("multu_rst", ALU_ADD, MD_MULTU, 32'd3, 32'd5, 32'd0, 1'b0, 2'b00, 2'b00, C_RW, 1'b1, 32'd0, 32'd0);
        run_independent("rst", 10);
        @(negedge clk);
        MdOpE = MD_MFLO; RegDstE = 1'b1; RegWriteE = 1'b1; MemtoRegE = 1'b1; MemWriteE = 1'b1;
        #1;
        total++;
        if (StallMD !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre_stall: StallMD=%b required 1", StallMD);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({ALUOutM, WriteDataM, WriteRegM, RegWriteM, MemtoRegM, MemWriteM, StallMD} !== '0) begin
            bad++;
            $display("FAIL rst_busy: alu=%h wd=%h wr=%0d ctl=%b%b%b stall=%b, required all 0",
                     ALUOutM, WriteDataM, WriteRegM, RegWriteM, MemtoRegM, MemWriteM, StallMD);
        end
        @(negedge clk);
        rst_n = 1'b1;
        op("rst_mflo", ALU_ADD, MD_MFLO, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 2'b00, C_RD, 1'b0, 32'd0, 32'd0);
        #1;
        total++;
        if (StallMD !== 1'b0) begin
            bad++;
            $display("FAIL rst_post_stall: StallMD=%b required 0", StallMD);
        end
        op("rst_mfhi", ALU_ADD, MD_MFHI, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 2'b00, C_RD, 1'b0, 32'd0, 32'd0);
        op("rst_after", ALU_ADD, MD_NONE, 32'd8, 32'd1, 32'd0, 1'b0, 2'b00, 2'b00, C_RW, 1'b0, 32'd9, 32'd1);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_multu_stall();
        test_back_to_back();
        test_divu();
        test_reset_busy();
        @(posedge clk);
        #2;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: %0d entries left, required 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
